// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcode, condition and NZCV encodings for the execute stage
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_EOR = 4'd4,
    OP_MOV = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8,
    OP_ROR = 4'd9,
    OP_CMP = 4'd10,
    OP_MUL = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Condition test against the committed NZCV value; NV never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    cond_pass = 1'b0;
    case (cond)
      CC_EQ: cond_pass = z;
      CC_NE: cond_pass = !z;
      CC_CS: cond_pass = c;
      CC_CC: cond_pass = !c;
      CC_MI: cond_pass = n;
      CC_PL: cond_pass = !n;
      CC_VS: cond_pass = v;
      CC_VC: cond_pass = !v;
      CC_HI: cond_pass = c && !z;
      CC_LS: cond_pass = !c || z;
      CC_GE: cond_pass = (n == v);
      CC_LT: cond_pass = (n != v);
      CC_GT: cond_pass = !z && (n == v);
      CC_LE: cond_pass = z || (n != v);
      CC_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - shift-add multiplier retiring one multiplier bit per cycle
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run;
  logic              r_done;

  // Load operands on start, then add the shifted multiplicand per set multiplier bit; pulse done after the last bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_run) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_LAST) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - conditional execute stage with single-cycle ALU and iterative multiply
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 11,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        cond_in,
  input  logic [DATA_W-1:0] rn_in,
  input  logic [DATA_W-1:0] rm_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              alu_src_in,
  input  logic [3:0]        alu_op_in,
  input  logic [3:0]        rd_in,
  input  logic              reg_write_en_in,
  input  logic              set_flags_in,
  input  logic              branch_in,
  input  logic [31:0]       branch_target_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic [3:0]        rd_out,
  output logic [31:0]       pc_out,
  output logic              reg_write_en_out,
  output logic              branch_taken_out,
  output logic [31:0]       branch_target_out,
  output logic [3:0]        flags_out,
  output logic              busy_out,
  input  logic              flush_in
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] w_imm_ext, w_op2, w_res, w_ror, w_mul_prod;
  logic [DATA_W:0]   w_sum, w_diff, w_lsl, w_lsr, w_asr;
  logic [SH_W-1:0]   w_sh;
  logic [SH_W:0]     w_sh_inv;
  logic [3:0]        w_nzcv;
  alu_op_e           w_op;
  logic              w_cond_ok, w_nop, w_accept, w_mul_start, w_out_free;
  logic              w_done_load, w_busy, w_mul_done, w_wr_en, w_flag_en;
  mul_state_e        r_state, w_state_nxt;

  logic              r_out_valid, r_we, r_br_taken, r_m_we, r_m_sf;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_rd, r_m_rd, r_flags;
  logic [31:0]       r_pc, r_m_pc, r_br_target;

  assign w_imm_ext = DATA_W'($signed(imm_in));
  assign w_op2     = alu_src_in ? w_imm_ext : rm_in;
  assign w_sh      = w_op2[SH_W-1:0];
  assign w_sh_inv  = (SH_W+1)'(DATA_W) - {1'b0, w_sh};
  assign w_sum     = {1'b0, rn_in} + {1'b0, w_op2};
  assign w_diff    = {1'b0, rn_in} + {1'b0, ~w_op2} + (DATA_W+1)'(1);
  // Shifts carry one guard bit so the last bit shifted out lands in a fixed position
  assign w_lsl     = {1'b0, rn_in} << w_sh;
  assign w_lsr     = {rn_in, 1'b0} >> w_sh;
  assign w_asr     = $signed({rn_in, 1'b0}) >>> w_sh;
  assign w_ror     = (rn_in >> w_sh) | (rn_in << w_sh_inv);
  assign w_op      = alu_op_e'(alu_op_in);
  assign w_cond_ok = cond_pass(cond_in, r_flags);

  // Single-cycle ALU result and candidate NZCV; C and V default to their committed values
  always_comb begin
    w_res  = '0;
    w_nzcv = r_flags;
    w_nop  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_nzcv[FLAG_C] = w_sum[DATA_W];
        w_nzcv[FLAG_V] = (rn_in[MSB] == w_op2[MSB]) && (w_sum[MSB] != rn_in[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_diff[MSB:0];
        w_nzcv[FLAG_C] = w_diff[DATA_W];
        w_nzcv[FLAG_V] = (rn_in[MSB] != w_op2[MSB]) && (w_diff[MSB] != rn_in[MSB]);
      end
      OP_AND: w_res = rn_in & w_op2;
      OP_ORR: w_res = rn_in | w_op2;
      OP_EOR: w_res = rn_in ^ w_op2;
      OP_MOV: w_res = w_op2;
      OP_LSL: begin
        w_res = w_lsl[MSB:0];
        if (w_sh != '0) w_nzcv[FLAG_C] = w_lsl[DATA_W];
      end
      OP_LSR: begin
        w_res = w_lsr[DATA_W:1];
        if (w_sh != '0) w_nzcv[FLAG_C] = w_lsr[0];
      end
      OP_ASR: begin
        w_res = w_asr[DATA_W:1];
        if (w_sh != '0) w_nzcv[FLAG_C] = w_asr[0];
      end
      OP_ROR: begin
        w_res = w_ror;
        if (w_sh != '0) w_nzcv[FLAG_C] = w_ror[MSB];
      end
      default: w_nop = 1'b1;
    endcase
    w_nzcv[FLAG_N] = w_res[MSB];
    w_nzcv[FLAG_Z] = (w_res == '0);
  end

  assign w_busy      = (r_state != S_IDLE);
  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = !w_busy && !flush_in && w_out_free;
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_op == OP_MUL) && (MUL_EN != 0);
  assign w_wr_en     = w_cond_ok && reg_write_en_in && !w_nop && (w_op != OP_CMP);
  assign w_flag_en   = w_cond_ok && (set_flags_in || (w_op == OP_CMP)) && !w_nop;

  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_mul_start),
        .i_a       (rn_in),
        .i_b       (w_op2),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  // Multiply sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Multiply sequencer next state; DONE waits for a free output stage, flush abandons everything
  always_comb begin
    w_state_nxt = r_state;
    w_done_load = 1'b0;
    case (r_state)
      S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_out_free) begin
          w_state_nxt = S_IDLE;
          w_done_load = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_in) begin
      w_state_nxt = S_IDLE;
      w_done_load = 1'b0;
    end
  end

  // Multiply context captured at acceptance; condition is resolved against the flags of that moment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_rd <= '0;
      r_m_pc <= '0;
      r_m_we <= 1'b0;
      r_m_sf <= 1'b0;
    end else if (w_mul_start) begin
      r_m_rd <= rd_in;
      r_m_pc <= pc_in;
      r_m_we <= w_cond_ok && reg_write_en_in;
      r_m_sf <= w_cond_ok && set_flags_in;
    end
  end

  // Output stage: load on ALU acceptance or multiply completion, hold while stalled, drain on out_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_we        <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_br_taken <= w_accept && branch_in && w_cond_ok;
      if (w_accept) r_br_target <= branch_target_in;
      if (flush_in) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && !w_mul_start) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_rd        <= rd_in;
        r_pc        <= pc_in;
        r_we        <= w_wr_en;
      end else if (w_done_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_prod;
        r_rd        <= r_m_rd;
        r_pc        <= r_m_pc;
        r_we        <= r_m_we;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Architected NZCV: ALU ops commit at acceptance, a multiply commits N/Z only when it retires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else if (w_accept && !w_mul_start && w_flag_en) begin
      r_flags <= w_nzcv;
    end else if (w_done_load && r_m_sf) begin
      r_flags[FLAG_N] <= w_mul_prod[MSB];
      r_flags[FLAG_Z] <= (w_mul_prod == '0);
    end
  end

  assign out_valid         = r_out_valid;
  assign result_out        = r_result;
  assign rd_out            = r_rd;
  assign pc_out            = r_pc;
  assign reg_write_en_out  = r_we;
  assign branch_taken_out  = r_br_taken;
  assign branch_target_out = r_br_target;
  assign flags_out         = r_flags;
  assign busy_out          = w_busy;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - directed self-checking bench for ex_stage_mc
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] pc_in;
  logic [3:0]  cond_in;
  logic [31:0] rn_in, rm_in;
  logic [10:0] imm_in;
  logic        alu_src_in;
  logic [3:0]  alu_op_in, rd_in;
  logic        reg_write_en_in, set_flags_in, branch_in;
  logic [31:0] branch_target_in;
  logic        out_valid, out_ready;
  logic [31:0] result_out;
  logic [3:0]  rd_out;
  logic [31:0] pc_out;
  logic        reg_write_en_out, branch_taken_out;
  logic [31:0] branch_target_out;
  logic [3:0]  flags_out;
  logic        busy_out, flush_in;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles, ready_seen, valid_seen;

  ex_stage_mc #(.DATA_W(32), .IMM_W(11), .MUL_EN(1)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .pc_in             (pc_in),
    .cond_in           (cond_in),
    .rn_in             (rn_in),
    .rm_in             (rm_in),
    .imm_in            (imm_in),
    .alu_src_in        (alu_src_in),
    .alu_op_in         (alu_op_in),
    .rd_in             (rd_in),
    .reg_write_en_in   (reg_write_en_in),
    .set_flags_in      (set_flags_in),
    .branch_in         (branch_in),
    .branch_target_in  (branch_target_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .result_out        (result_out),
    .rd_out            (rd_out),
    .pc_out            (pc_out),
    .reg_write_en_out  (reg_write_en_out),
    .branch_taken_out  (branch_taken_out),
    .branch_target_out (branch_target_out),
    .flags_out         (flags_out),
    .busy_out          (busy_out),
    .flush_in          (flush_in)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] rn,
                       input logic [31:0] rm, input logic src, input logic [10:0] imm,
                       input logic [3:0] rd, input logic [31:0] pc, input logic we, input logic sf);
    alu_op_in       = op;
    cond_in         = cond;
    rn_in           = rn;
    rm_in           = rm;
    alu_src_in      = src;
    imm_in          = imm;
    rd_in           = rd;
    pc_in           = pc;
    reg_write_en_in = we;
    set_flags_in    = sf;
    branch_in       = 1'b0;
    in_valid        = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush_in = 1'b0;
    pc_in = '0; cond_in = 4'd14; rn_in = '0; rm_in = '0; imm_in = '0; alu_src_in = 1'b0;
    alu_op_in = '0; rd_in = '0; reg_write_en_in = 1'b0; set_flags_in = 1'b0;
    branch_in = 1'b0; branch_target_in = '0;
    repeat (2) tick();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_branch", 32'(branch_taken_out), 32'd0);
    check("rst_we", 32'(reg_write_en_out), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_target", branch_target_out, 32'd0);
    reset_n = 1'b1;

    drive(OP_ADD, 4'd14, 32'h7FFF_FFFF, 32'd1, 1'b0, 11'd0, 4'd2, 32'h10, 1'b1, 1'b1);
    check("add_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", result_out, 32'h8000_0000);
    check("add_rd", 32'(rd_out), 32'd2);
    check("add_pc", pc_out, 32'h10);
    check("add_we", 32'(reg_write_en_out), 32'd1);
    check("add_flags", 32'(flags_out), 32'h9);

    drive(OP_CMP, 4'd14, 32'd5, 32'd5, 1'b0, 11'd0, 4'd1, 32'h14, 1'b1, 1'b0);
    tick();
    check("cmp_we", 32'(reg_write_en_out), 32'd0);
    check("cmp_flags", 32'(flags_out), 32'h6);
    drive(OP_ADD, 4'd1, 32'd1, 32'd2, 1'b0, 11'd0, 4'd3, 32'h18, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    check("addne_valid", 32'(out_valid), 32'd1);
    check("addne_rd", 32'(rd_out), 32'd3);
    check("addne_we", 32'(reg_write_en_out), 32'd0);
    check("addne_flags", 32'(flags_out), 32'h6);

    drive(OP_SUB, 4'd14, 32'd3, 32'd0, 1'b1, 11'h7FF, 4'd4, 32'h1C, 1'b1, 1'b1);
    tick();
    check("subimm_result", result_out, 32'd4);
    check("subimm_flags", 32'(flags_out), 32'h0);
    drive(OP_LSL, 4'd14, 32'h8000_0001, 32'd1, 1'b0, 11'd0, 4'd4, 32'h1C, 1'b1, 1'b1);
    tick();
    check("lsl_result", result_out, 32'd2);
    check("lsl_flags", 32'(flags_out), 32'h2);
    drive(OP_LSR, 4'd14, 32'd3, 32'd0, 1'b1, 11'd0, 4'd4, 32'h1C, 1'b1, 1'b1);
    tick();
    check("lsr0_result", result_out, 32'd3);
    check("lsr0_flags", 32'(flags_out), 32'h2);
    drive(OP_ASR, 4'd14, 32'h8000_0000, 32'd4, 1'b0, 11'd0, 4'd4, 32'h1C, 1'b1, 1'b1);
    tick();
    check("asr_result", result_out, 32'hF800_0000);
    check("asr_flags", 32'(flags_out), 32'h8);
    drive(OP_ROR, 4'd14, 32'd1, 32'd1, 1'b0, 11'd0, 4'd4, 32'h1C, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    check("ror_result", result_out, 32'h8000_0000);
    check("ror_flags", 32'(flags_out), 32'hA);

    drive(OP_ADD, 4'd14, 32'd10, 32'd20, 1'b0, 11'd0, 4'd5, 32'h20, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(OP_ORR, 4'd14, 32'hF0, 32'h0F, 1'b0, 11'd0, 4'd6, 32'h24, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", result_out, 32'd30);
      check("stall_rd", 32'(rd_out), 32'd5);
      check("stall_pc", pc_out, 32'h20);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("release_rd", 32'(rd_out), 32'd6);
    check("release_result", result_out, 32'hFF);

    drive(OP_MOV, 4'd14, 32'd0, 32'd0, 1'b0, 11'd0, 4'd8, 32'h30, 1'b0, 1'b0);
    branch_in = 1'b1; branch_target_in = 32'h100;
    tick(); in_valid = 1'b0; branch_in = 1'b0;
    check("br_taken", 32'(branch_taken_out), 32'd1);
    check("br_target", branch_target_out, 32'h100);
    tick();
    check("br_pulse_end", 32'(branch_taken_out), 32'd0);
    drive(OP_MOV, 4'd15, 32'd0, 32'd0, 1'b0, 11'd0, 4'd8, 32'h34, 1'b1, 1'b0);
    branch_in = 1'b1; branch_target_in = 32'h200;
    tick(); in_valid = 1'b0; branch_in = 1'b0;
    check("br_nv_taken", 32'(branch_taken_out), 32'd0);
    check("br_nv_we", 32'(reg_write_en_out), 32'd0);
    check("br_nv_valid", 32'(out_valid), 32'd1);

    drive(OP_MUL, 4'd14, 32'h1234, 32'h10, 1'b0, 11'd0, 4'd7, 32'h40, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    busy_cycles = 0; ready_seen = 0;
    for (int i = 0; i < 100 && busy_out; i++) begin
      busy_cycles++;
      if (in_ready) ready_seen++;
      tick();
    end
    check("mul_busy_cycles", 32'(busy_cycles), 32'd34);
    check("mul_in_ready_low", 32'(ready_seen), 32'd0);
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_result", result_out, 32'h12340);
    check("mul_rd", 32'(rd_out), 32'd7);
    check("mul_we", 32'(reg_write_en_out), 32'd1);
    check("mul_flags", 32'(flags_out), 32'h2);

    drive(OP_MUL, 4'd14, 32'd0, 32'd5, 1'b0, 11'd0, 4'd8, 32'h44, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    repeat (9) tick();
    check("flush_busy_before", 32'(busy_out), 32'd1);
    flush_in = 1'b1;
    drive(OP_ADD, 4'd14, 32'd1, 32'd1, 1'b0, 11'd0, 4'd9, 32'h48, 1'b1, 1'b1);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick(); flush_in = 1'b0; in_valid = 1'b0;
    check("flush_busy", 32'(busy_out), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    valid_seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) valid_seen++;
    end
    check("flush_no_output", 32'(valid_seen), 32'd0);
    check("flush_flags", 32'(flags_out), 32'h2);

    drive(OP_MUL, 4'd14, 32'd3, 32'd3, 1'b0, 11'd0, 4'd10, 32'h50, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    repeat (5) tick();
    check("rstmul_busy_before", 32'(busy_out), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmul_busy", 32'(busy_out), 32'd0);
    check("rstmul_valid", 32'(out_valid), 32'd0);
    check("rstmul_flags", 32'(flags_out), 32'd0);
    check("rstmul_result", result_out, 32'd0);
    tick();
    reset_n = 1'b1;
    drive(OP_ADD, 4'd14, 32'd1, 32'd1, 1'b0, 11'd0, 4'd4, 32'h60, 1'b1, 1'b1);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_result", result_out, 32'd2);
    check("post_rst_rd", 32'(rd_out), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
